// File: rtl/multicycle_ctrl.sv
// Multicycle CPU main control FSM.
// Sequences fetch, decode, execute, memory and writeback, drives the ALU
// operation and datapath selects every cycle, and handshakes with the shared
// instruction/data memory through mem_req/mem_ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RESET    | idle after reset, every output 0
// FETCH    | read instruction at PC, PC+4 computed; wait for mem_ready
// DECODE   | latch op/funct, branch target into ALUOut, dispatch
// EXEC_R   | R-type ALU operation
// EXEC_I   | I-type ALU operation with extended immediate
// WB_R     | write R-type result to rd (suppressed on trapping overflow)
// WB_I     | write I-type result to rt (suppressed on trapping overflow)
// MEM_ADDR | compute load/store address A + sign-extended imm
// MEM_RD   | load request at ALUOut; wait for mem_ready
// MEM_WR   | store request at ALUOut; wait for mem_ready
// WB_MEM   | write MDR to rt
// BRANCH   | compare and conditionally load PC from ALUOut
// JUMP     | load PC with jump target, jal also writes PC to RA
// JR       | load PC from rs
module multicycle_ctrl #(
    parameter int RA_INDEX = 31,
    parameter int ALUCTR_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                alu_zero,
    input  logic                alu_negative,
    input  logic                alu_overflow,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_source,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ext_op,
    output logic [ALUCTR_W-1:0] alu_ctr,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                ovf_exc,
    output logic                illegal,
    output logic [3:0]          state
);

    // The register file owns the RA_INDEX decode (reg_dst=10); here it is
    // only sanity-checked so a bad override fails at elaboration.
    if (RA_INDEX < 0 || RA_INDEX > 31) begin : g_bad_ra_index
        $error("RA_INDEX must select one of 32 registers");
    end
    if (ALUCTR_W != 4) begin : g_bad_aluctr_w
        $error("ALUCTR_W is fixed at 4 by the ALU encoding");
    end

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_LUI  = 4'b1110;
    localparam logic [3:0] ALU_CMP  = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_R     = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JR       = 4'd13
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    logic       ovf_q, ovf_d;
    logic       trap_insn;

    function automatic logic r_funct_ok(input logic [5:0] f);
        case (f)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07:
                r_funct_ok = 1'b1;
            default: r_funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            6'h20:        r_alu = ALU_ADD;
            6'h21:        r_alu = ALU_ADDU;
            6'h22:        r_alu = ALU_SUB;
            6'h23:        r_alu = ALU_SUBU;
            6'h24:        r_alu = ALU_AND;
            6'h25:        r_alu = ALU_OR;
            6'h26:        r_alu = ALU_XOR;
            6'h27:        r_alu = ALU_NOR;
            6'h2A:        r_alu = ALU_SLT;
            6'h2B:        r_alu = ALU_SLTU;
            6'h00, 6'h04: r_alu = ALU_SLL;
            6'h02, 6'h06: r_alu = ALU_SRL;
            6'h03, 6'h07: r_alu = ALU_SRA;
            default:      r_alu = ALU_ADDU;
        endcase
    endfunction

    function automatic logic [3:0] i_alu(input logic [5:0] o);
        case (o)
            OP_ADDI:  i_alu = ALU_ADD;
            OP_ADDIU: i_alu = ALU_ADDU;
            OP_SLTI:  i_alu = ALU_SLT;
            OP_SLTIU: i_alu = ALU_SLTU;
            OP_ANDI:  i_alu = ALU_AND;
            OP_ORI:   i_alu = ALU_OR;
            OP_XORI:  i_alu = ALU_XOR;
            OP_LUI:   i_alu = ALU_LUI;
            default:  i_alu = ALU_ADDU;
        endcase
    endfunction

    // State register plus the instruction fields and overflow flag captured
    // for the later cycles of the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            op_q    <= '0;
            funct_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            ovf_q   <= ovf_d;
        end
    end

    // Capture op/funct in DECODE and the ALU overflow flag in either EXEC state.
    always_comb begin
        op_d    = op_q;
        funct_d = funct_q;
        ovf_d   = ovf_q;
        if (state_q == S_DECODE) begin
            op_d    = op;
            funct_d = funct;
        end
        if (state_q == S_EXEC_R || state_q == S_EXEC_I) begin
            ovf_d = alu_overflow;
        end
    end

    // Only the signed add/sub forms trap on overflow; the unsigned ones wrap.
    always_comb begin
        trap_insn = ((op_q == OP_RTYPE) && (funct_q == FN_ADD || funct_q == FN_SUB))
                    || (op_q == OP_ADDI);
    end

    // Next-state and Moore/Mealy outputs; everything defaults to 0.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        alu_ctr    = ALU_ADDU;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        ovf_exc    = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            state_d = S_JR;
                        end else if (r_funct_ok(funct)) begin
                            state_d = S_EXEC_R;
                        end else begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_d = S_BRANCH;
                    OP_J, OP_JAL:                     state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                // Immediate shifts take shamt as the left operand.
                if (funct_q == 6'h00 || funct_q == 6'h02 || funct_q == 6'h03) begin
                    alu_src_a = 2'b10;
                end else begin
                    alu_src_a = 2'b01;
                end
                alu_ctr = r_alu(funct_q);
                state_d = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                ext_op    = !(op_q == OP_ANDI || op_q == OP_ORI || op_q == OP_XORI);
                alu_ctr   = i_alu(op_q);
                state_d   = S_WB_I;
            end
            S_WB_R, S_WB_I: begin
                reg_dst = (state_q == S_WB_R) ? 2'b01 : 2'b00;
                if (trap_insn && ovf_q) begin
                    ovf_exc = 1'b1;
                end else begin
                    reg_write = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                alu_ctr   = ALU_ADD;
                state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                pc_source = 2'b01;
                case (op_q)
                    OP_BEQ: begin
                        alu_ctr  = ALU_SUB;
                        pc_write = alu_zero;
                    end
                    OP_BNE: begin
                        alu_ctr  = ALU_SUB;
                        pc_write = !alu_zero;
                    end
                    OP_BLEZ: begin
                        alu_ctr  = ALU_CMP;
                        pc_write = alu_zero || alu_negative;
                    end
                    default: begin
                        alu_ctr  = ALU_CMP;
                        pc_write = !alu_zero && !alu_negative;
                    end
                endcase
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                if (op_q == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                state_d = S_FETCH;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                state_d   = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    assign state = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle variant of the CPU datapath. It sits at the initiating end of the ALU interface and sequences fetch, decode, execute, memory and writeback. In every state it drives ALUctr using the existing ALU operation encoding, and it consumes the ALU zero/negative/overflow flags. It also performs a req/ready handshake with the shared instruction/data memory.

Parameters:
RA_INDEX, 31, register index written by jal.
ALUCTR_W, 4, width of ALU operation code (fixed at 4).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag
alu_negative  in  1  ALU negative flag
alu_overflow  in  1  ALU overflow flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request active
mem_we  out  1  1=store, 0=read (qualified by mem_req)
iord  out  1  address select: 0=PC, 1=ALUOut
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs reg
alu_src_a  out  2  00 PC, 01 A reg, 10 zero-extended shamt
alu_src_b  out  2  00 B reg, 01 const 4, 10 ext imm, 11 ext imm<<2
ext_op  out  1  1=sign-extend, 0=zero-extend
alu_ctr  out  4  ALU operation
reg_write  out  1  register file write enable
reg_dst  out  2  00 rt, 01 rd, 10 RA_INDEX
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
ovf_exc  out  1  one-cycle pulse: signed overflow, writeback suppressed
illegal  out  1  one-cycle pulse: unsupported op/funct
state  out  4  current state (debug)

Behaviour:
- Reset (rst_n low, asynchronous): state=RESET. All outputs are 0, including state=0.
- RESET -> FETCH on the first clock edge after rst_n rises.
- ALU codes: Addu 0000, Subu 0001, Add 0010, Sub 0011, And 0100, Or 0101, Xor 0110, Nor 0111, Slt 1000, Sltu 1001, Sll 1010, Srl 1011, Sra 1100, Lui 1110, Cmp 1111.
- FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_ctr=Addu, pc_source=00. ir_write and pc_write are asserted only in a cycle with mem_ready=1, which also moves to DECODE. Otherwise FETCH holds with no writes.
- DECODE: alu_src_a=00, alu_src_b=11, ext_op=1, alu_ctr=Addu (branch target into ALUOut). op and funct are latched internally here.
- DECODE next-state:
  - R-type (op=0): jr (funct 08) -> JR; other supported funct -> EXEC_R.
  - addi/addiu/slti/sltiu/andi/ori/xori/lui -> EXEC_I.
  - lw/sw -> MEM_ADDR.
  - beq/bne/blez/bgtz -> BRANCH.
  - j/jal -> JUMP.
  - Anything else -> FETCH with illegal=1 for that cycle.
- EXEC_R: alu_src_b=00.
  - sll/srl/sra: alu_src_a=10.
  - sllv/srlv/srav: alu_src_a=01. Note lhs is the shift amount.
  - All others: alu_src_a=01.
  - funct map: 20 Add, 21 Addu, 22 Sub, 23 Subu, 24 And, 25 Or, 26 Xor, 27 Nor, 2A Slt, 2B Sltu, 00/04 Sll, 02/06 Srl, 03/07 Sra.
  - Next -> WB_R.
- EXEC_I: alu_src_a=01, alu_src_b=10.
  - ext_op=0 for andi/ori/xori, 1 otherwise.
  - op map: addi Add, addiu Addu, slti Slt, sltiu Sltu, andi And, ori Or, xori Xor, lui Lui.
  - Next -> WB_I.
- WB_R / WB_I: mem_to_reg=00; reg_dst=01 (WB_R) or 00 (WB_I).
  - reg_write=1 unless the instruction is add/sub/addi and alu_overflow was 1 in the EXEC cycle (latched). In that case reg_write=0 and ovf_exc=1.
  - Next -> FETCH.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, ext_op=1, alu_ctr=Add. Next -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD / MEM_WR: mem_req=1, iord=1, mem_we=1 in MEM_WR only. State holds until mem_ready=1.
  - On mem_ready: MEM_RD -> WB_MEM; MEM_WR -> FETCH.
- WB_MEM: reg_write=1, reg_dst=00, mem_to_reg=01. Next -> FETCH.
- BRANCH: alu_src_a=01, pc_source=01.
  - beq/bne: alu_src_b=00, alu_ctr=Sub.
  - blez/bgtz: alu_ctr=Cmp.
  - pc_write=1 iff taken:
    - beq: zero.
    - bne: !zero.
    - blez: zero|negative.
    - bgtz: !zero&!negative.
  - Next -> FETCH.
- JUMP: pc_write=1, pc_source=10. For jal also reg_write=1, reg_dst=10, mem_to_reg=10 (PC already +4). Next -> FETCH.
- JR: pc_write=1, pc_source=11. Next -> FETCH.
- Latency with mem_ready tied high:
  - R/I-type and sw: 4 cycles.
  - lw: 5 cycles.
  - Branch/j/jal/jr: 3 cycles.
  - Each cycle mem_ready is low adds one cycle.
- Any output not listed for a state is 0 in that state.
- Reset asserted mid-instruction forces RESET immediately. No partial write may occur after the reset edge.

Test Plan:
- Release reset, mem_ready=1, IR=addu $3,$1,$2 (op 0, funct 21) -> states FETCH, DECODE, EXEC_R (alu_ctr=0000, src_a=01, src_b=00), WB_R (reg_write=1, reg_dst=01); back in FETCH on cycle 5.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEM_RD -> ir_write/pc_write only on the ready cycle; reg_write in WB_MEM with mem_to_reg=01; 10 cycles total.
- beq with alu_zero=1, then with alu_zero=0 -> pc_write=1/pc_source=01 in BRANCH for the first case; pc_write=0 for the second.
- blez/bgtz with flag pairs (zero,negative)=(0,0),(1,0),(0,1) -> blez taken on the last two only; bgtz taken on the first only; alu_ctr=1111.
- addi with alu_overflow=1 in EXEC_I -> WB_I has reg_write=0 and ovf_exc=1 for exactly 1 cycle; addiu under the same condition writes normally.
- jal -> JUMP cycle has pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. op=0x3F -> illegal pulse, return to FETCH. rst_n low during MEM_WR -> all outputs 0 immediately.
